// File: rtl/mnist_pkg.sv
// mnist_pkg: constants and types shared by the classifier result path.
//   NUM_CLASSES / LANE_W / IDX_W : score vector geometry (10 lanes x 8-bit signed)
//   state_t                      : argmax scan FSM encoding
//   score_vec_t / best_t         : captured score vector and running best entry
//   beats()                      : signed "strictly greater" test used by the scan
package mnist_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int LANE_W      = 8;
  localparam int IDX_W       = 4;
  localparam int VEC_W       = NUM_CLASSES * LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [NUM_CLASSES-1:0][LANE_W-1:0] score_vec_t;

  typedef struct packed {
    logic [IDX_W-1:0]         idx;
    logic signed [LANE_W-1:0] val;
  } best_t;

  // Strictly greater only: an equal score never displaces the earlier
  // (lower-index) winner.
  function automatic logic beats(input logic signed [LANE_W-1:0] cand,
                                 input logic signed [LANE_W-1:0] cur);
    return cand > cur;
  endfunction

endpackage

// File: rtl/led_hold_timer.sv
// led_hold_timer: stretches a "result matched" event into a fixed-length LED
// on-time.
//   clk, rst_n : clock, asynchronous active-low reset
//   trigger    : one-cycle pulse, a new result is being presented
//   match      : qualifies trigger; the result is the expected class
//   led        : high for HOLD_CYCLES cycles starting the cycle after a
//                matching trigger; a matching trigger restarts the count,
//                a non-matching trigger turns the LED off at once
module led_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic match,
  output logic led
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(HOLD_CYCLES - 1);

  // cnt holds the number of on-cycles still to go after the current one.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      led <= 1'b0;
    end else if (trigger) begin
      cnt <= match ? LOAD : '0;
      led <= match;
    end else if (led) begin
      if (cnt == '0) led <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/result_argmax.sv
// result_argmax: picks the winning class out of a 10-lane signed score vector.
// A frame's end beat (din_vld & din_end) is captured while idle, then scanned
// one lane per cycle; the winner is presented with a one-cycle result_vld ten
// cycles after capture. End beats arriving mid-scan are dropped and flagged.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din_vld     : score beat valid
//   din_end     : last beat of frame (only end beats are captured)
//   din         : ten signed 8-bit scores, lane i = din[8i+7:8i]
//   busy        : high while a captured vector is scanned (SCAN and DONE)
//   result_vld  : one-cycle result pulse
//   result_idx  : winning index 0..9, held until the next result
//   result_max  : winning signed score, held until the next result
//   ovf         : sticky, an end beat was dropped while busy
//   led         : match indicator
//
// Build option: define ARGMAX_LED_HOLD_EN to drive led from a hold timer
// (HOLD_CYCLES on-time after a result whose index equals EXPECTED_IDX).
// Without it led is tied low and no timer exists.
module result_argmax
  import mnist_pkg::*;
#(
  parameter int               HOLD_CYCLES  = 50_000_000,
  parameter logic [IDX_W-1:0] EXPECTED_IDX = 4'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_vld,
  input  logic              din_end,
  input  logic [VEC_W-1:0]  din,
  output logic              busy,
  output logic              result_vld,
  output logic [IDX_W-1:0]  result_idx,
  output logic [LANE_W-1:0] result_max,
  output logic              ovf,
  output logic              led
);

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_CLASSES - 1);

  state_t           state;
  score_vec_t       vec;
  best_t            best;
  best_t            nxt_best;
  logic [IDX_W-1:0] lane_cnt;
  logic             end_beat;
  logic             lane_wins;

  assign end_beat = din_vld & din_end;

  // Candidate lane for this SCAN cycle against the running best.
  assign lane_wins = beats(vec[lane_cnt], best.val);

  always_comb begin
    nxt_best = best;
    if (lane_wins) begin
      nxt_best.idx = lane_cnt;
      nxt_best.val = vec[lane_cnt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      best       <= '0;
      lane_cnt   <= '0;
      busy       <= 1'b0;
      result_vld <= 1'b0;
      result_idx <= '0;
      result_max <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          result_vld <= 1'b0;
          if (end_beat) begin
            // Lane 0 seeds the best so the scan only has lanes 1..9 left.
            vec      <= din;
            best.idx <= '0;
            best.val <= din[LANE_W-1:0];
            lane_cnt <= IDX_W'(1);
            busy     <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best <= nxt_best;
          if (lane_cnt == LAST_LANE) begin
            // Publish straight from the final compare so result_vld lands
            // in the single DONE cycle.
            result_vld <= 1'b1;
            result_idx <= nxt_best.idx;
            result_max <= nxt_best.val;
            lane_cnt   <= '0;
            state      <= ST_DONE;
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          result_vld <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          result_vld <= 1'b0;
          busy       <= 1'b0;
          lane_cnt   <= '0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // busy mirrors SCAN|DONE, so any end beat seen while it is high is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ovf <= 1'b0;
    else if (busy && end_beat) ovf <= 1'b1;
  end

`ifdef ARGMAX_LED_HOLD_EN
  logic idx_match;
  assign idx_match = (result_idx == EXPECTED_IDX);

  led_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_led_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .trigger (result_vld),
    .match   (idx_match),
    .led     (led)
  );
`else
  assign led = 1'b0;
`endif

endmodule

// File: tb/tb_result_argmax.sv
module tb_result_argmax;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic        din_end = 1'b0;
  logic [79:0] din = '0;
  logic        busy, result_vld, ovf, led;
  logic [3:0]  result_idx;
  logic [7:0]  result_max;

  result_argmax #(.HOLD_CYCLES(20), .EXPECTED_IDX(4'd7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_vld    (din_vld),
    .din_end    (din_end),
    .din        (din),
    .busy       (busy),
    .result_vld (result_vld),
    .result_idx (result_idx),
    .result_max (result_max),
    .ovf        (ovf),
    .led        (led)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  int led_cycles = 0;

  always @(negedge clk) begin
    if (result_vld) pulses++;
    if (led) led_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain argmax over signed lanes, first maximum wins.
  task automatic ref_argmax(input logic [79:0] v, output logic [3:0] idx, output logic [7:0] mx);
    int best_i;
    int best_v;
    best_i = 0;
    best_v = $signed(v[7:0]);
    for (int i = 1; i < 10; i++)
      if ($signed(v[8*i +: 8]) > best_v) begin
        best_i = i;
        best_v = $signed(v[8*i +: 8]);
      end
    idx = 4'(best_i);
    mx  = 8'(best_v);
  endtask

  function automatic logic [79:0] fill(input logic [7:0] b);
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[8*i +: 8] = b;
    return v;
  endfunction

  function automatic logic [79:0] rnd_vec();
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  // Drive one end beat, optionally inject a second end beat at scan cycle
  // drop_at, wait (bounded) for the result and check latency and value.
  task automatic run_frame(input string tag, input logic [79:0] v, input int drop_at);
    logic [3:0] e_idx;
    logic [7:0] e_max;
    int lat;
    ref_argmax(v, e_idx, e_max);
    @(negedge clk);
    din = v; din_vld = 1'b1; din_end = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        din = rnd_vec(); din_vld = 1'b1; din_end = 1'b1;
      end else begin
        din_vld = 1'b0; din_end = 1'b0;
      end
      if (k == 1) chk({tag, " busy_scan"}, 32'(busy), 32'd1);
      if (result_vld) begin
        lat = k;
        break;
      end
    end
    din_vld = 1'b0; din_end = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'd10);
    chk({tag, " idx"}, 32'(result_idx), 32'(e_idx));
    chk({tag, " max"}, 32'(result_max), 32'(e_max));
  endtask

  initial begin
    logic [79:0] v;
    logic [3:0]  e_idx;
    logic [7:0]  e_max;
    int p0, l0, gap, a, b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst vld", 32'(result_vld), 32'd0);
    chk("rst idx", 32'(result_idx), 32'd0);
    chk("rst max", 32'(result_max), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst led", 32'(led), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios
    v = fill(8'hFB); v[8*3 +: 8] = 8'd100;
    run_frame("lane3", v, 0);
    v = fill(8'h00); v[8*2 +: 8] = 8'd50; v[8*6 +: 8] = 8'd50;
    run_frame("tie", v, 0);
    v = fill(8'h80); v[8*9 +: 8] = 8'hFF;
    run_frame("signed", v, 0);
    v = fill(8'h80);
    run_frame("all_min", v, 0);
    v = fill(8'h7F);
    run_frame("all_max", v, 0);

    // Random frames with random idle gaps (0 = back-to-back) and ignored
    // non-end beats in the gaps.
    for (int f = 0; f < 24; f++) begin
      v = rnd_vec();
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, 9);
        b = $urandom_range(0, 9);
        v[8*b +: 8] = v[8*a +: 8];
      end
      run_frame("rand", v, 0);
      ref_argmax(v, e_idx, e_max);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap vld", 32'(result_vld), 32'd0);
        chk("gap busy", 32'(busy), 32'd0);
        chk("gap hold", 32'({result_idx, result_max}), 32'({e_idx, e_max}));
        din = rnd_vec(); din_vld = 1'($urandom_range(0, 1)); din_end = 1'b0;
      end
      din_vld = 1'b0;
    end
    chk("ovf clear", 32'(ovf), 32'd0);

    // Overflow: second end beat mid-scan is dropped
    p0 = pulses;
    v = fill(8'h10); v[8*5 +: 8] = 8'd90;
    run_frame("ovf", v, 4);
    repeat (15) @(negedge clk);
    chk("ovf flag", 32'(ovf), 32'd1);
    chk("ovf pulses", 32'(pulses - p0), 32'd1);
    chk("ovf idle", 32'(busy), 32'd0);

    // Reset mid-scan
    p0 = pulses;
    @(negedge clk);
    din = rnd_vec(); din_vld = 1'b1; din_end = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      din_vld = 1'b0; din_end = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst vld", 32'(result_vld), 32'd0);
    chk("mrst idx", 32'(result_idx), 32'd0);
    chk("mrst max", 32'(result_max), 32'd0);
    chk("mrst ovf", 32'(ovf), 32'd0);
    chk("mrst led", 32'(led), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mrst pulses", 32'(pulses - p0), 32'd0);
    chk("mrst idle", 32'(busy), 32'd0);
    v = fill(8'h01); v[8*4 +: 8] = 8'd9;
    run_frame("recover", v, 0);

`ifdef ARGMAX_LED_HOLD_EN
    // Matching winner lights the LED for exactly 20 cycles
    v = fill(8'hF0); v[8*7 +: 8] = 8'd60;
    run_frame("led7", v, 0);
    chk("led7 done", 32'(led), 32'd0);
    l0 = led_cycles;
    @(negedge clk);
    chk("led7 on", 32'(led), 32'd1);
    repeat (39) @(negedge clk);
    chk("led7 count", 32'(led_cycles - l0), 32'd20);
    v = fill(8'hF0); v[8*3 +: 8] = 8'd60;
    run_frame("led3", v, 0);
    l0 = led_cycles;
    repeat (40) @(negedge clk);
    chk("led3 count", 32'(led_cycles - l0), 32'd0);
`else
    l0 = 0;
    chk("led tied", 32'(led_cycles), 32'(l0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_argmax.md
RESULT_ARGMAX -- requirements
Module: result_argmax

Interface
- REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning LED on-time in clk cycles (1 s at 50 MHz).
- REQ-002 SHALL have parameter EXPECTED_IDX, default 4'd7, meaning the class index that lights the LED.
- REQ-003 SHALL have port clk, input, 1, the single clock for all state.
- REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-005 SHALL have port din_vld, input, 1, score beat valid from the classifier.
- REQ-006 SHALL have port din_end, input, 1, last beat of a frame.
- REQ-007 SHALL have port din, input, 80, ten signed 8-bit class scores; lane i = din[8i+7:8i].
- REQ-008 SHALL have port busy, output, 1, high while a captured vector is being scanned.
- REQ-009 SHALL have port result_vld, output, 1, one-cycle pulse marking a result.
- REQ-010 SHALL have port result_idx, output, 4, winning class index 0..9.
- REQ-011 SHALL have port result_max, output, 8, signed winning score.
- REQ-012 SHALL have port ovf, output, 1, sticky flag: an end beat was dropped while busy.
- REQ-013 SHALL have port led, output, 1, match indicator.

Function
- REQ-014 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
- REQ-015 SHALL, in IDLE, capture din only when din_vld=1 and din_end=1 in the same cycle; din_vld with din_end=0 is ignored.
- REQ-016 SHALL, on capture, load best_idx=0, best_val=lane0, lane counter=1, and enter SCAN.
- REQ-017 SHALL, in SCAN, compare one lane per cycle (lanes 1..9) as signed 8-bit, replacing best only on strictly greater; ties keep the lower index.
- REQ-018 SHALL leave SCAN for DONE after lane 9 is compared; DONE lasts exactly one cycle, then IDLE.
- REQ-019 SHALL assert result_vld for exactly one cycle in DONE; for a capture in cycle N, result_vld is high in cycle N+10.
- REQ-020 SHALL hold result_idx/result_max stable from DONE until the next DONE.
- REQ-021 SHALL drive busy=1 in SCAN and DONE, and 0 in IDLE.
- REQ-022 SHALL drop any din_vld&din_end beat arriving while busy=1 and set ovf=1 (sticky until reset).
- REQ-023 SHALL accept a new capture in the first IDLE cycle after DONE (back-to-back period 11 cycles).

Reset
- REQ-024 SHALL, on rst_n low, immediately force state=IDLE, busy=0, result_vld=0, result_idx=0, result_max=0, ovf=0, led=0, and clear counters.
- REQ-025 SHALL discard a scan interrupted by reset with no result_vld.

Configuration
- REQ-026 SHALL, with ARGMAX_LED_HOLD_EN defined, set led=1 for HOLD_CYCLES cycles starting the cycle after a DONE with result_idx==EXPECTED_IDX; a new matching DONE restarts the count; a non-matching DONE clears led.
- REQ-027 SHALL, without ARGMAX_LED_HOLD_EN, tie led to 0 and omit the hold counter.

Structure
- REQ-028 SHALL take NUM_CLASSES=10, LANE_W=8, IDX_W=4 and the FSM state encoding from shared package mnist_pkg.
- REQ-029 SHALL place the hold counter in sub-module led_hold_timer (trigger, match -> led), instantiated only under ARGMAX_LED_HOLD_EN.

Verification
- REQ-030 SHALL cover this scenario: scores lane3=+100, others -5, vld+end in cycle 0 -> result_vld in cycle 10, idx=3, max=100.
- REQ-031 SHALL cover this scenario: lane2=lane6=+50, others 0 -> idx=2 (tie keeps lowest).
- REQ-032 SHALL cover this scenario: all lanes -128 except lane9=-1 -> idx=9, max=-1 (signed compare).
- REQ-033 SHALL cover this scenario: second end beat at cycle 4 of a scan -> beat dropped, ovf=1, exactly one result_vld.
- REQ-034 SHALL cover this scenario: rst_n low at cycle 5 of a scan -> no result_vld and all outputs at reset values.
- REQ-035 SHALL cover this scenario: with macro and HOLD_CYCLES=20, winner 7 -> led high exactly 20 cycles; winner 3 -> led stays 0.
